regdump_ctrl: RTL and testbench

REGDUMP_CTRL -- requirements
Module: regdump_ctrl

---
 rtl/regdump_ctrl_pkg.sv | 21 ++
 rtl/regdump_ser.sv | 45 ++++
 rtl/regdump_ctrl.sv | 119 +++++++++++
 tb/tb_regdump_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_ctrl_pkg.sv
// Shared definitions for the register-dump controller: FSM state encoding,
// default header byte and a small state-decode helper.
package regdump_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SEND   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // States in which a byte is offered to the UART transmitter.
  function automatic logic is_tx_state(input state_t s);
    return (s == ST_HEADER) || (s == ST_SEND) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/regdump_ser.sv
// Byte serializer for the register dump: holds the 32-bit word being sent,
// counts bytes within the word and keeps the running XOR checksum.
module regdump_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_shift,
  output logic [7:0]  o_byte,
  output logic [1:0]  o_bcnt,
  output logic [7:0]  o_csum
);

  logic [31:0] r_shift;
  logic [1:0]  r_bcnt;
  logic [7:0]  r_csum;

  // Load a fresh word, or shift out the accepted MSB byte and fold it into the checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_bcnt  <= '0;
      r_csum  <= '0;
    end else begin
      if (i_load) begin
        r_shift <= i_word;
        r_bcnt  <= '0;
      end else if (i_shift) begin
        r_shift <= {r_shift[23:0], 8'h00};
        r_bcnt  <= r_bcnt + 2'd1;
      end
      if (i_clr) begin
        r_csum <= '0;
      end else if (i_shift) begin
        r_csum <= r_csum ^ r_shift[31:24];
      end
    end
  end

  assign o_byte = r_shift[31:24];
  assign o_bcnt = r_bcnt;
  assign o_csum = r_csum;

endmodule

// File: rtl/regdump_ctrl.sv
// Register-dump controller: freezes the CPU, streams a sync byte, every
// register MSB first and a closing XOR checksum to a UART transmitter.
module regdump_ctrl
  import regdump_ctrl_pkg::*;
#(
  parameter int         NREGS = 32,
  parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        cpu_hold,
  output logic [5:0]  uart_ra,
  input  logic [31:0] uart_rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_idx;
  logic [4:0]  w_idx_nxt;
  logic        r_busy;
  logic        r_done;
  logic        r_tx_valid;
  logic [5:0]  r_uart_ra;

  logic        w_accept;
  logic        w_last_byte;
  logic [7:0]  w_byte;
  logic [1:0]  w_bcnt;
  logic [7:0]  w_csum;

  assign w_accept    = r_tx_valid & tx_ready;
  assign w_last_byte = (r_state == ST_SEND) && w_accept && (w_bcnt == 2'd3);

  regdump_ser u_ser (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   ((r_state == ST_HEADER) && w_accept),
    .i_load  (r_state == ST_LOAD),
    .i_word  (uart_rd),
    .i_shift ((r_state == ST_SEND) && w_accept),
    .o_byte  (w_byte),
    .o_bcnt  (w_bcnt),
    .o_csum  (w_csum)
  );

  // Next-state and next-register-index decision.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_HEADER;
      ST_HEADER: begin
        if (w_accept) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = '0;
        end
      end
      ST_LOAD:   w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (w_last_byte) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = r_idx + 5'd1;
          end
        end
      end
      ST_CHECK:  if (w_accept) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state plus control outputs registered from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_uart_ra  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
      r_tx_valid <= is_tx_state(w_state_nxt);
      r_uart_ra  <= (w_state_nxt == ST_LOAD) ? {1'b0, w_idx_nxt} : 6'd0;
    end
  end

  // Byte offered to the transmitter, selected from registered state only so it holds through stalls.
  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      ST_HEADER: tx_data = SYNC;
      ST_SEND:   tx_data = w_byte;
      ST_CHECK:  tx_data = w_csum;
      default:   tx_data = 8'h00;
    endcase
  end

  assign busy     = r_busy;
  assign cpu_hold = r_busy;
  assign done     = r_done;
  assign tx_valid = r_tx_valid;
  assign uart_ra  = r_uart_ra;

endmodule

// File: tb/tb_regdump_ctrl.sv
// Scoreboard bench for regdump_ctrl: a reference model expands the register
// file into the expected byte stream; a negedge monitor checks every accepted byte.
module tb_regdump_ctrl;

  localparam int         NREGS = 32;
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         DUMP_CYCLES = 1 + 5 * NREGS + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        cpu_hold;
  logic [5:0]  uart_ra;
  logic [31:0] uart_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic [31:0] regs [NREGS];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q [$];
  int          exp_done = 0;
  int          done_seen = 0;
  int          ready_mode = 0;
  bit          check_len = 1'b0;
  int          busy_cycles = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  regdump_ctrl #(.NREGS(NREGS), .SYNC(SYNC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cpu_hold (cpu_hold),
    .uart_ra  (uart_ra),
    .uart_rd  (uart_rd),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  assign uart_rd = regs[uart_ra[4:0]];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: sync byte, each register big-endian, XOR of the data bytes.
  task automatic push_dump();
    logic [7:0] cs;
    logic [7:0] by;
    cs = 8'h00;
    exp_q.push_back(SYNC);
    for (int r = 0; r < NREGS; r++) begin
      for (int b = 3; b >= 0; b--) begin
        by = regs[r][8*b +: 8];
        exp_q.push_back(by);
        cs = cs ^ by;
      end
    end
    exp_q.push_back(cs);
    exp_done++;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    int base;
    c = 0;
    base = done_seen;
    while (done_seen == base && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (done_seen == base) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no done, expected done within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_dump(input string name, input int mode, input bit chk);
    ready_mode = mode;
    check_len  = chk;
    push_dump();
    pulse_start();
    wait_done(name, 2000);
  endtask

  // Transmitter model: always ready, random ready, or three stall cycles per byte.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: begin
          if (tx_valid) begin
            if (stall_cnt < 3) begin
              tx_ready = 1'b0;
              stall_cnt++;
            end else begin
              tx_ready = 1'b1;
              stall_cnt = 0;
            end
          end else begin
            tx_ready = 1'($urandom_range(0, 1));
          end
        end
      endcase
    end
  end

  // Monitor: scoreboard pops, handshake stability and invariant checks.
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_outputs", 32'({busy, done, cpu_hold, tx_valid, tx_data, uart_ra}), 32'd0);
      prev_stall  = 1'b0;
      busy_cycles = 0;
    end else begin
      check("cpu_hold_eq_busy", 32'(cpu_hold), 32'(busy));
      if (tx_valid || !busy) check("uart_ra_outside_load", 32'(uart_ra), 32'd0);
      if (prev_stall) begin
        check("valid_held_in_stall", 32'(tx_valid), 32'd1);
        check("data_stable_in_stall", 32'(tx_data), 32'(prev_data));
      end
      if (busy) busy_cycles++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected no byte", tx_data);
        end else begin
          check("stream_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (done) begin
        check("done_expected", 32'(exp_done > 0), 32'd1);
        check("bytes_left_at_done", 32'(exp_q.size()), 32'd0);
        if (check_len) check("dump_cycles", 32'(busy_cycles), 32'(DUMP_CYCLES));
        if (exp_done > 0) exp_done--;
        busy_cycles = 0;
        done_seen++;
      end
    end
  end

  initial begin
    int c;
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NREGS; i++) regs[i] = 32'(i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    reset = 1'b1;

    // regs[i] = i, transmitter always ready, exact dump length
    run_dump("dump_index_pattern", 0, 1'b1);

    // single non-zero register, rest zero
    for (int i = 0; i < NREGS; i++) regs[i] = 32'd0;
    regs[1] = 32'h12345678;
    run_dump("dump_single_reg", 0, 1'b1);

    // random data with three stall cycles on every byte
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    run_dump("dump_stall3", 2, 1'b0);

    // random data with random ready
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    run_dump("dump_random_ready", 1, 1'b0);

    // start held high: one dump, then a new one only after an IDLE cycle
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    ready_mode = 0;
    check_len  = 1'b1;
    push_dump();
    @(posedge clk); #1;
    start = 1'b1;
    wait_done("dump_start_held", 2000);
    #1;
    check("busy_low_after_done", 32'(busy), 32'd0);
    push_dump();
    @(posedge clk); #1;
    check("restart_after_idle", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("dump_restart", 2000);

    // reset while sending register 5
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    ready_mode = 0;
    check_len  = 1'b1;
    push_dump();
    pulse_start();
    c = 0;
    while (uart_ra != 6'd5 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("reached_reg5_load", 32'(uart_ra), 32'd5);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("midreset_outputs", 32'({busy, done, cpu_hold, tx_valid, tx_data, uart_ra}), 32'd0);
    exp_q.delete();
    exp_done = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_abort", 32'({busy, done}), 32'd0);
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    run_dump("dump_after_reset", 0, 1'b1);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
